clk_div_prog: RTL

- Multi-channel, runtime-programmable integer clock divider. Successor to the fixed div2/div4/div8 divider.
- Each of NCH channels divides `clk` by its own divisor D, set at reset from a parameter and reloaded through a valid/ready config port.
- Per channel it produces a square-wave enable-clock (`clk_out`) and a one-cycle `tick` strobe.
- Sits at the top of the fabric, feeding timers, UART baud logic and LED/scan blocks. All outputs are in the `clk` domain.

---
 rtl/clk_div_pkg.sv | 14 +
 rtl/clk_div_chan.sv | 78 +++++++
 rtl/clk_div_prog.sv | 56 +++++
 3 files changed

// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the programmable clock divider.
package clk_div_pkg;

  localparam int unsigned MIN_DIV = 2;

  function automatic int unsigned clamp_div(input int unsigned x);
    return (x < MIN_DIV) ? MIN_DIV : x;
  endfunction

  function automatic int unsigned half(input int unsigned d);
    return d >> 1;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, active/pending divisor and registered clk_out/tick.
// Outputs are registered from next state. A load is refused while a divisor is still pending.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int             W       = 8,
  parameter logic [W-1:0]   DEF_DIV = W'(2)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         sync,
  input  logic         ld_valid,
  input  logic [W-1:0] ld_div,
  output logic         pend_busy,
  output logic         clk_out,
  output logic         tick
);

  localparam logic [W-1:0] RST_DIV = W'(clamp_div(32'(DEF_DIV)));

  logic [W-1:0] cnt, act_div, pend_div;
  logic         pend_vld;
  logic [W-1:0] cnt_nx, act_nx, pend_div_nx;
  logic         pend_vld_nx, clk_out_nx, tick_nx;

  always_comb begin
    cnt_nx      = cnt;
    act_nx      = act_div;
    pend_div_nx = pend_div;
    pend_vld_nx = pend_vld;
    if (sync) begin
      cnt_nx = '0;
      if (pend_vld) begin
        act_nx      = pend_div;
        pend_vld_nx = 1'b0;
      end
    end else if (en) begin
      if (cnt == act_div - W'(1)) begin
        cnt_nx = '0;
        if (pend_vld) begin
          act_nx      = pend_div;
          pend_vld_nx = 1'b0;
        end
      end else begin
        cnt_nx = cnt + W'(1);
      end
    end
    // A load in a wrap or sync cycle only becomes pending; it waits for the next boundary.
    if (ld_valid) begin
      pend_div_nx = W'(clamp_div(32'(ld_div)));
      pend_vld_nx = 1'b1;
    end
    clk_out_nx = (cnt_nx >= W'(half(32'(act_nx))));
    tick_nx    = en && !sync && (cnt_nx == act_nx - W'(1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      act_div  <= RST_DIV;
      pend_div <= RST_DIV;
      pend_vld <= 1'b0;
      clk_out  <= 1'b0;
      tick     <= 1'b0;
    end else begin
      cnt      <= cnt_nx;
      act_div  <= act_nx;
      pend_div <= pend_div_nx;
      pend_vld <= pend_vld_nx;
      clk_out  <= clk_out_nx;
      tick     <= tick_nx;
    end
  end

  assign pend_busy = pend_vld;

endmodule

// File: rtl/clk_div_prog.sv
// Multi-channel programmable clock divider: config decode plus one channel per output.
// Config latency <= remaining period + 1; cfg_ready drops while the addressed channel has a pending divisor.
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int                 NCH      = 3,
  parameter int                 W        = 8,
  parameter logic [NCH*W-1:0]   DEF_DIVS = {8'd8, 8'd4, 8'd2},
  localparam int                CW       = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           en,
  input  logic           sync,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [CW-1:0]  cfg_ch,
  input  logic [W-1:0]   cfg_div,
  output logic [NCH-1:0] clk_out,
  output logic [NCH-1:0] tick
);

  logic [NCH-1:0] busy;
  logic [NCH-1:0] ld;

  // Out-of-range channels fall through with ready=1 and no load, i.e. accepted and dropped.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < NCH; i++)
      if (cfg_ch == CW'(i)) cfg_ready = !busy[i];
  end

  always_comb begin
    ld = '0;
    for (int i = 0; i < NCH; i++)
      ld[i] = cfg_valid && cfg_ready && (cfg_ch == CW'(i));
  end

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    clk_div_chan #(
      .W       (W),
      .DEF_DIV (DEF_DIVS[g*W +: W])
    ) u_chan (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .sync      (sync),
      .ld_valid  (ld[g]),
      .ld_div    (cfg_div),
      .pend_busy (busy[g]),
      .clk_out   (clk_out[g]),
      .tick      (tick[g])
    );
  end

endmodule
